// File: rtl/seg_capture_monitor.sv
// rtl/seg_capture_monitor.sv - seven-segment capture, glitch filter, decode and FIFO
// Optional macro SEG_CAPTURE_DP_EN includes dp_in in the sampled word and rd_data[5].
module seg_capture_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int DEPTH         = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [6:0]               segments_in,
    input  logic                     dp_in,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [5:0]               rd_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               event_count,
    output logic                     overflow,
    input  logic                     clr_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic       dp_eff;
`ifdef SEG_CAPTURE_DP_EN
    assign dp_eff = dp_in;
`else
    logic unused_dp;
    assign unused_dp = dp_in;
    assign dp_eff    = 1'b0;
`endif

    logic [7:0] pattern;
    logic [7:0] sample_reg;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;
    logic [7:0] last_reg;
    logic       last_valid;
    logic       differs;
    logic       accept;
    logic       push_req;
    logic       push_ok;
    logic       pop;
    logic       full;
    logic [4:0] dec;
    logic [5:0] entry;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [5:0] mem [DEPTH];

    // Returns {invalid, digit}; anything outside the 16 hex glyphs is invalid.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F: decode = 5'h00;
            7'h06: decode = 5'h01;
            7'h5B: decode = 5'h02;
            7'h4F: decode = 5'h03;
            7'h66: decode = 5'h04;
            7'h6D: decode = 5'h05;
            7'h7D: decode = 5'h06;
            7'h07: decode = 5'h07;
            7'h7F: decode = 5'h08;
            7'h6F: decode = 5'h09;
            7'h77: decode = 5'h0A;
            7'h7C: decode = 5'h0B;
            7'h39: decode = 5'h0C;
            7'h5E: decode = 5'h0D;
            7'h79: decode = 5'h0E;
            7'h71: decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    assign pattern  = {dp_eff, segments_in};
    assign differs  = (pattern != sample_reg);
    assign cnt_inc  = (cnt == STABLE) ? cnt : cnt + 8'd1;
    // A new pattern counts as its first stable edge, so STABLE_CYCLES=1 accepts immediately.
    assign accept   = ena && (differs ? (STABLE == 8'd1)
                                      : ((cnt != STABLE) && (cnt_inc == STABLE)));
    assign push_req = accept && (!last_valid || (last_reg != pattern));
    assign dec      = decode(pattern[6:0]);
    assign entry    = {pattern[7], dec};

    assign fifo_count = wr_ptr - rd_ptr;
    assign full       = fifo_count[AW];
    assign rd_valid   = (wr_ptr != rd_ptr);
    assign pop        = rd_valid && rd_ready;
    assign push_ok    = push_req && (!full || pop);
    assign rd_data    = rd_valid ? mem[rd_ptr[AW-1:0]] : 6'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_reg  <= 8'd0;
            cnt         <= 8'd0;
            last_reg    <= 8'd0;
            last_valid  <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            event_count <= 8'd0;
            overflow    <= 1'b0;
        end else begin
            if (ena) begin
                if (differs) begin
                    sample_reg <= pattern;
                    cnt        <= 8'd1;
                end else begin
                    cnt <= cnt_inc;
                end
            end
            if (push_req) begin
                last_reg    <= pattern;
                last_valid  <= 1'b1;
                event_count <= event_count + 8'd1;
            end
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_req && full && !pop) overflow <= 1'b1;
            else if (clr_ovf)             overflow <= 1'b0;
        end
    end

    // Storage needs no reset; rd_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= entry;
    end
endmodule

// File: tb/tb_seg_capture_monitor.sv
// tb/tb_seg_capture_monitor.sv - directed scoreboard bench for seg_capture_monitor
module tb_seg_capture_monitor;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [6:0] segments_in;
    logic       dp_in;
    logic       rd_ready;
    logic       rd_valid;
    logic [5:0] rd_data;
    logic [3:0] fifo_count;
    logic [7:0] event_count;
    logic       overflow;
    logic       clr_ovf;

    int total = 0;
    int bad   = 0;
    logic [5:0] exp_q[$];
    logic [5:0] exp_head;

    seg_capture_monitor #(.STABLE_CYCLES(4), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .segments_in(segments_in),
        .dp_in(dp_in), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .fifo_count(fifo_count), .event_count(event_count),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [6:0] seg, input int n);
        segments_in = seg;
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_event", 32'(event_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_data", 32'(rd_data), 0);
        exp_q.delete();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && rd_valid; i++) begin
            if (exp_q.size() == 0) begin
                chk("extra_entry", 32'(rd_valid), 0);
            end else begin
                exp_head = exp_q.pop_front();
                chk("pop_data", 32'(rd_data), 32'(exp_head));
            end
            rd_ready = 1'b1;
            cyc();
            rd_ready = 1'b0;
        end
        chk("drain_valid", 32'(rd_valid), 0);
        chk("drain_sb_left", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b1; ena = 1'b1; segments_in = 7'h00; dp_in = 1'b0;
        rd_ready = 1'b0; clr_ovf = 1'b0;
        #3;
        do_reset();

        // First-entry latency and single accept for a held pattern
        hold(7'h5B, 3);
        chk("lat_before", 32'(rd_valid), 0);
        exp_q.push_back(6'h02);
        hold(7'h5B, 1);
        chk("lat_after", 32'(rd_valid), 1);
        chk("lat_data", 32'(rd_data), 32'h02);
        hold(7'h5B, 20);
        chk("held_once", 32'(fifo_count), 1);
        drain();
        chk("pop_count", 32'(fifo_count), 0);

        // Glitch filter
        hold(7'h06, 3);
        exp_q.push_back(6'h03);
        hold(7'h4F, 6);
        chk("glitch_one", 32'(fifo_count), 1);
        hold(7'h00, 2);
        hold(7'h4F, 6);
        chk("glitch_same", 32'(fifo_count), 1);
        chk("glitch_event", 32'(event_count), 2);
        drain();

        // Invalid glyph and ena freeze
        exp_q.push_back(6'h10);
        hold(7'h49, 4);
        chk("invalid_cnt", 32'(fifo_count), 1);
        drain();
        ena = 1'b0;
        hold(7'h66, 10);
        chk("ena_freeze", 32'(fifo_count), 0);
        ena = 1'b1;
        hold(7'h66, 3);
        chk("ena_pre", 32'(fifo_count), 0);
        exp_q.push_back(6'h04);
        hold(7'h66, 1);
        chk("ena_post", 32'(fifo_count), 1);
        chk("ena_event", 32'(event_count), 4);
        drain();

        // Mid-stream reset with entries queued
        hold(7'h3F, 4); hold(7'h06, 4); hold(7'h3F, 4);
        chk("pre_rst_count", 32'(fifo_count), 3);
        do_reset();
        exp_q.push_back(6'h00);
        hold(7'h3F, 4);
        chk("post_rst_count", 32'(fifo_count), 1);
        chk("post_rst_event", 32'(event_count), 1);
        drain();

        // Overflow: nine alternating digits with no reads
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back((i % 2 == 0) ? 6'h00 : 6'h01);
            hold((i % 2 == 0) ? 7'h3F : 7'h06, 4);
        end
        chk("ovf_count", 32'(fifo_count), 8);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_event", 32'(event_count), 9);
        chk("ovf_head", 32'(rd_data), 32'h00);
        hold(7'h06, 3);
        rd_ready = 1'b1;
        exp_head = exp_q.pop_front();
        exp_q.push_back(6'h01);
        hold(7'h06, 1);
        rd_ready = 1'b0;
        chk("full_pushpop_count", 32'(fifo_count), 8);
        chk("full_pushpop_event", 32'(event_count), 10);
        chk("full_pushpop_head", 32'(rd_data), 32'h01);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_ovf_count", 32'(fifo_count), 8);
        chk("clr_ovf_event", 32'(event_count), 10);
        drain();

        // Decimal point handling
        dp_in = 1'b0;
        exp_q.push_back(6'h00);
        hold(7'h3F, 4);
        dp_in = 1'b1;
`ifdef SEG_CAPTURE_DP_EN
        exp_q.push_back(6'h20);
`endif
        hold(7'h3F, 6);
        dp_in = 1'b0;
        drain();
        chk("final_data", 32'(rd_data), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
